ps2_kbd_fifo: RTL and testbench

- Parametrised keyboard capture block between the PS/2 controller receive side and the CPU keyboard port; replaces the single-register toggle-handshake capture.
- Handles F0 (break), E0 (extended) and E1 (Pause) prefixes and discards controller error bytes.
- Queues decoded codes in a DEPTH-entry FIFO with pop handshake, fill count and sticky overflow.
- RAW mode bypasses decoding and queues AT bytes unmodified.

---
 rtl/ps2_kbd_fifo_pkg.sv | 36 +++
 rtl/ps2_kbd_fifo_fifo.sv | 73 +++++++
 rtl/ps2_kbd_fifo.sv | 151 +++++++++++++++
 tb/tb_ps2_kbd_fifo.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_kbd_fifo_pkg.sv
// Shared definitions for the PS/2 keyboard capture block.
// Holds the AT prefix bytes, the Pause skip length, the decoder state enum and the queue entry layout.
package ps2_kbd_fifo_pkg;

    // AT set-2 prefix and error bytes from the PS/2 controller
    localparam logic [7:0] AT_BREAK = 8'hF0;
    localparam logic [7:0] AT_EXT   = 8'hE0;
    localparam logic [7:0] AT_PAUSE = 8'hE1;
    localparam logic [7:0] AT_ERR0  = 8'h00;
    localparam logic [7:0] AT_ERR1  = 8'hFF;

    // Number of bytes that follow E1 in a Pause sequence
    localparam int PAUSE_SKIP = 7;
    localparam int SKIP_W     = 3;

    // The counter is loaded with PAUSE_SKIP-1, so the byte that arrives
    // with the counter at zero is the last byte of the sequence
    localparam logic [SKIP_W-1:0] SKIP_LOAD = SKIP_W'(PAUSE_SKIP - 1);

    localparam int ENTRY_W = 9;

    typedef enum logic {
        S_NORM = 1'b0,
        S_SKIP = 1'b1
    } kbd_state_t;

    typedef struct packed {
        logic       ext;
        logic [7:0] code;
    } kbd_entry_t;

    function automatic logic is_err_byte(input logic [7:0] b);
        return (b == AT_ERR0) || (b == AT_ERR1);
    endfunction

endpackage

// File: rtl/ps2_kbd_fifo_fifo.sv
// Generic synchronous first-word-fall-through FIFO.
// Ports: i_clk, i_rst (sync, active-high), i_push/i_din, i_pop, o_dout (head), o_empty, o_full, o_count, o_drop (push refused).
module kbd_fifo #(
    parameter int W     = 9,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_push,
    input  logic [W-1:0]  i_din,
    input  logic          i_pop,
    output logic [W-1:0]  o_dout,
    output logic          o_empty,
    output logic          o_full,
    output logic [AW:0]   o_count,
    output logic          o_drop
);

    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_cnt;

    logic w_empty;
    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign w_empty   = (r_cnt == '0);
    assign w_full    = (r_cnt == FULL_CNT);
    assign w_do_pop  = i_pop && !w_empty;
    // A full queue still accepts a push when the head leaves in the same cycle
    assign w_do_push = i_push && (!w_full || w_do_pop);

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr] <= i_din;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_do_push) begin
                r_wr <= r_wr + PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd <= r_rd + PTR_ONE;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_cnt <= r_cnt + CNT_ONE;
                2'b01:   r_cnt <= r_cnt - CNT_ONE;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Head is forced to zero while empty so the output is defined after reset
    assign o_dout  = w_empty ? '0 : r_mem[r_rd];
    assign o_empty = w_empty;
    assign o_full  = w_full;
    assign o_count = r_cnt;
    assign o_drop  = i_push && w_full && !w_do_pop;

endmodule

// File: rtl/ps2_kbd_fifo.sv
// PS/2 keyboard capture: decodes F0/E0/E1 prefixes, drops 00/FF error bytes and queues {ext, code} entries for the CPU.
// Ports: clock, reset (sync), rx_at/rx_xt/rx_valid in; pop, clr_ovf in; kb_hit, kb_ch, kb_ext, count, ovf, err out.
module ps2_kbd_fifo
    import ps2_kbd_fifo_pkg::*;
#(
    parameter int         DEPTH      = 8,
    parameter int         AW         = $clog2(DEPTH),
    parameter bit         RAW        = 1'b0,
    parameter logic [7:0] PAUSE_CODE = 8'h45
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  rx_at,
    input  logic [7:0]  rx_xt,
    input  logic        rx_valid,
    input  logic        pop,
    input  logic        clr_ovf,
    output logic        kb_hit,
    output logic [7:0]  kb_ch,
    output logic        kb_ext,
    output logic [AW:0] count,
    output logic        ovf,
    output logic        err
);

    kbd_state_t        r_state;
    logic              r_rel;
    logic              r_ext;
    logic [SKIP_W-1:0] r_skip;
    logic              r_err;
    logic              r_ovf;

    kbd_state_t        w_state_nxt;
    logic              w_rel_nxt;
    logic              w_ext_nxt;
    logic [SKIP_W-1:0] w_skip_nxt;
    logic              w_err_nxt;
    logic              w_push;
    kbd_entry_t        w_din;
    kbd_entry_t        w_head;
    logic              w_empty;
    logic              w_full;
    logic              w_drop;
    logic [7:0]        w_code;

    // Codes with bit 7 set in the XT table keep their own value;
    // otherwise bit 7 carries the break flag
    assign w_code = rx_xt[7] ? rx_xt : {r_rel, rx_xt[6:0]};

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_NORM;
            r_rel   <= 1'b0;
            r_ext   <= 1'b0;
            r_skip  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rel   <= w_rel_nxt;
            r_ext   <= w_ext_nxt;
            r_skip  <= w_skip_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rel_nxt   = r_rel;
        w_ext_nxt   = r_ext;
        w_skip_nxt  = r_skip;
        w_err_nxt   = 1'b0;
        w_push      = 1'b0;
        w_din       = '0;
        if (rx_valid) begin
            if (RAW) begin
                w_push = 1'b1;
                w_din  = '{ext: 1'b0, code: rx_at};
            end else begin
                unique case (r_state)
                    S_NORM: begin
                        if (rx_at == AT_BREAK) begin
                            w_rel_nxt = 1'b1;
                        end else if (rx_at == AT_EXT) begin
                            w_ext_nxt = 1'b1;
                        end else if (rx_at == AT_PAUSE) begin
                            w_skip_nxt  = SKIP_LOAD;
                            w_state_nxt = S_SKIP;
                        end else if (is_err_byte(rx_at)) begin
                            w_err_nxt = 1'b1;
                            w_rel_nxt = 1'b0;
                            w_ext_nxt = 1'b0;
                        end else begin
                            w_push    = 1'b1;
                            w_din     = '{ext: r_ext, code: w_code};
                            w_rel_nxt = 1'b0;
                            w_ext_nxt = 1'b0;
                        end
                    end
                    S_SKIP: begin
                        // Pause bytes are swallowed blindly, even 00/FF
                        if (r_skip == '0) begin
                            w_push      = 1'b1;
                            w_din       = '{ext: 1'b1, code: PAUSE_CODE};
                            w_state_nxt = S_NORM;
                        end else begin
                            w_skip_nxt = r_skip - SKIP_W'(1);
                        end
                    end
                endcase
            end
        end
    end

    kbd_fifo #(
        .W     (ENTRY_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .i_clk   (clock),
        .i_rst   (reset),
        .i_push  (w_push),
        .i_din   (w_din),
        .i_pop   (pop),
        .o_dout  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_count (count),
        .o_drop  (w_drop)
    );

    // A new overflow beats a simultaneous clear
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (clr_ovf) begin
            r_ovf <= 1'b0;
        end
    end

    assign kb_hit = !w_empty;
    assign kb_ch  = w_head.code;
    assign kb_ext = w_head.ext;
    assign ovf    = r_ovf;
    assign err    = r_err;

    logic w_unused;
    assign w_unused = w_full;

endmodule

// File: tb/tb_ps2_kbd_fifo.sv
// Bench for ps2_kbd_fifo: a decoded DEPTH=8 instance and a RAW DEPTH=4 instance share one input stream.
// Vector table, hand sequences, then random traffic against a queue-based reference model.
module tb_ps2_kbd_fifo;

    localparam int D0 = 8;
    localparam int D1 = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_at;
    logic [7:0] rx_xt;
    logic       rx_valid;
    logic       pop;
    logic       clr_ovf;

    logic       hit0, ext0, ovf0, err0;
    logic [7:0] ch0;
    logic [3:0] cnt0;
    logic       hit1, ext1, ovf1, err1;
    logic [7:0] ch1;
    logic [2:0] cnt1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ps2_kbd_fifo #(.DEPTH(D0), .RAW(1'b0)) dut0 (
        .clock(clk), .reset(reset), .rx_at(rx_at), .rx_xt(rx_xt),
        .rx_valid(rx_valid), .pop(pop), .clr_ovf(clr_ovf),
        .kb_hit(hit0), .kb_ch(ch0), .kb_ext(ext0), .count(cnt0),
        .ovf(ovf0), .err(err0)
    );

    ps2_kbd_fifo #(.DEPTH(D1), .RAW(1'b1)) dut1 (
        .clock(clk), .reset(reset), .rx_at(rx_at), .rx_xt(rx_xt),
        .rx_valid(rx_valid), .pop(pop), .clr_ovf(clr_ovf),
        .kb_hit(hit1), .kb_ch(ch1), .kb_ext(ext1), .count(cnt1),
        .ovf(ovf1), .err(err1)
    );

    // Reference model: per-instance queue plus prefix bookkeeping
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    bit         m_rel[2];
    bit         m_ext[2];
    int         m_pl[2];
    bit         m_ovf[2];
    bit         m_err[2];

    task automatic model_step(input int k, input bit r, input bit v,
                              input logic [7:0] a, input logic [7:0] x,
                              input bit p, input bit c);
        bit         push;
        logic [8:0] d;
        bit         e;
        int         sz;
        int         dep;
        bit         pe;
        bit         ov;
        push = 0;
        d    = '0;
        e    = 0;
        dep  = (k == 0) ? D0 : D1;
        if (r) begin
            m_rel[k] = 0; m_ext[k] = 0; m_pl[k] = 0;
            m_ovf[k] = 0; m_err[k] = 0;
            if (k == 0) q0.delete(); else q1.delete();
            return;
        end
        if (v) begin
            if (k == 1) begin
                push = 1;
                d = {1'b0, a};
            end else if (m_pl[k] > 0) begin
                m_pl[k]--;
                if (m_pl[k] == 0) begin
                    push = 1;
                    d = {1'b1, 8'h45};
                end
            end else if (a == 8'hF0) begin
                m_rel[k] = 1;
            end else if (a == 8'hE0) begin
                m_ext[k] = 1;
            end else if (a == 8'hE1) begin
                m_pl[k] = 7;
            end else if (a == 8'h00 || a == 8'hFF) begin
                e = 1;
                m_rel[k] = 0;
                m_ext[k] = 0;
            end else begin
                push = 1;
                d[8] = m_ext[k];
                d[7:0] = x[7] ? x : {m_rel[k], x[6:0]};
                m_rel[k] = 0;
                m_ext[k] = 0;
            end
        end
        sz = (k == 0) ? q0.size() : q1.size();
        pe = p && (sz > 0);
        ov = push && (sz == dep) && !pe;
        if (k == 0) begin
            if (pe) void'(q0.pop_front());
            if (push && !ov) q0.push_back(d);
        end else begin
            if (pe) void'(q1.pop_front());
            if (push && !ov) q1.push_back(d);
        end
        if (ov) m_ovf[k] = 1;
        else if (c) m_ovf[k] = 0;
        m_err[k] = e;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input bit r, input bit v, input logic [7:0] a,
                        input logic [7:0] x, input bit p, input bit c);
        reset    = r;
        rx_valid = v;
        rx_at    = a;
        rx_xt    = x;
        pop      = p;
        clr_ovf  = c;
        model_step(0, r, v, a, x, p, c);
        model_step(1, r, v, a, x, p, c);
        @(posedge clk);
        #1;
    endtask

    task automatic cmp_model(input int k, input int n);
        logic [8:0] h;
        if (k == 0) begin
            chk($sformatf("r%0d d0 hit", n), int'(hit0), int'(q0.size() != 0));
            chk($sformatf("r%0d d0 cnt", n), int'(cnt0), q0.size());
            chk($sformatf("r%0d d0 ovf", n), int'(ovf0), int'(m_ovf[0]));
            chk($sformatf("r%0d d0 err", n), int'(err0), int'(m_err[0]));
            if (q0.size() != 0) begin
                h = q0[0];
                chk($sformatf("r%0d d0 head", n), int'({ext0, ch0}), int'(h));
            end
        end else begin
            chk($sformatf("r%0d d1 hit", n), int'(hit1), int'(q1.size() != 0));
            chk($sformatf("r%0d d1 cnt", n), int'(cnt1), q1.size());
            chk($sformatf("r%0d d1 ovf", n), int'(ovf1), int'(m_ovf[1]));
            chk($sformatf("r%0d d1 err", n), int'(err1), int'(m_err[1]));
            if (q1.size() != 0) begin
                h = q1[0];
                chk($sformatf("r%0d d1 head", n), int'({ext1, ch1}), int'(h));
            end
        end
    endtask

    typedef struct {
        bit         rst;
        bit         v;
        logic [7:0] at;
        logic [7:0] xt;
        bit         p;
        bit         c;
        bit         hit;
        logic [7:0] ch;
        bit         ext;
        int         cnt;
        bit         ovf;
        bit         err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit rst, bit v, logic [7:0] at, logic [7:0] xt,
                                bit p, bit c, bit hit, logic [7:0] ch,
                                bit ext, int cnt, bit ovf, bit err);
        vec_t t;
        t.rst = rst; t.v = v; t.at = at; t.xt = xt; t.p = p; t.c = c;
        t.hit = hit; t.ch = ch; t.ext = ext; t.cnt = cnt;
        t.ovf = ovf; t.err = err;
        return t;
    endfunction

    initial begin
        logic [7:0] a;
        logic [7:0] x;
        logic [7:0] e8;
        bit         r, v, p, c;
        int         sel;

        reset = 1'b1; rx_valid = 0; rx_at = '0; rx_xt = '0;
        pop = 0; clr_ovf = 0;

        //            rst v  at     xt     p c  hit ch     ext cnt ovf err
        tbl.push_back(mk(1, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h1C, 8'h1E, 0, 0, 1, 8'h1E, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'hF0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h1C, 8'h1E, 0, 0, 1, 8'h9E, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'hE0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'hF0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h75, 8'h48, 0, 0, 1, 8'hC8, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'hE1, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h14, 8'h1D, 0, 0, 0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h77, 8'h45, 0, 0, 0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'hE1, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'hF0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h14, 8'h1D, 0, 0, 0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'hF0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h77, 8'h45, 0, 0, 1, 8'h45, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h1C, 8'h1E, 0, 0, 1, 8'h1E, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'hF0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'hFF, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h1C, 8'h1E, 0, 0, 1, 8'h1E, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'hE0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 8'h1C, 8'h1E, 0, 0, 1, 8'h1E, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'hF0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h58, 8'hBA, 0, 0, 1, 8'hBA, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            tick(tbl[i].rst, tbl[i].v, tbl[i].at, tbl[i].xt, tbl[i].p, tbl[i].c);
            chk($sformatf("t%0d hit", i), int'(hit0), int'(tbl[i].hit));
            chk($sformatf("t%0d cnt", i), int'(cnt0), tbl[i].cnt);
            chk($sformatf("t%0d ovf", i), int'(ovf0), int'(tbl[i].ovf));
            chk($sformatf("t%0d err", i), int'(err0), int'(tbl[i].err));
            if (tbl[i].hit) begin
                chk($sformatf("t%0d ch", i), int'(ch0), int'(tbl[i].ch));
                chk($sformatf("t%0d ext", i), int'(ext0), int'(tbl[i].ext));
            end
            if (tbl[i].rst) begin
                chk("reset ch", int'(ch0), 0);
                chk("reset ext", int'(ext0), 0);
                chk("reset cnt raw", int'(cnt1), 0);
            end
        end

        // Overflow: nine pushes into eight entries
        tick(1, 0, 8'h00, 8'h00, 0, 0);
        for (int i = 1; i <= 9; i++) begin
            tick(0, 1, 8'(8'h10 + i), 8'(8'h20 + i), 0, 0);
        end
        chk("full cnt", int'(cnt0), 8);
        chk("full ovf", int'(ovf0), 1);
        chk("full head", int'(ch0), 8'h21);
        tick(0, 1, 8'h1A, 8'h2A, 1, 0);
        chk("pushpop cnt", int'(cnt0), 8);
        chk("pushpop ovf", int'(ovf0), 1);
        chk("pushpop head", int'(ch0), 8'h22);
        tick(0, 0, 8'h00, 8'h00, 0, 1);
        chk("clr ovf", int'(ovf0), 0);
        tick(0, 1, 8'h1B, 8'h2B, 0, 1);
        chk("clr+ovf set wins", int'(ovf0), 1);
        chk("drop cnt", int'(cnt0), 8);
        chk("drop head", int'(ch0), 8'h22);
        tick(0, 0, 8'h00, 8'h00, 0, 1);
        chk("clr ovf2", int'(ovf0), 0);
        for (int j = 0; j < 8; j++) begin
            e8 = (j < 7) ? 8'(8'h22 + j) : 8'h2A;
            chk($sformatf("drain %0d", j), int'(ch0), int'(e8));
            tick(0, 0, 8'h00, 8'h00, 1, 0);
        end
        chk("drain cnt", int'(cnt0), 0);
        chk("drain hit", int'(hit0), 0);

        // RAW instance queues every byte untouched
        tick(1, 0, 8'h00, 8'h00, 0, 0);
        tick(0, 1, 8'hF0, 8'h00, 0, 0);
        tick(0, 1, 8'h1C, 8'h1E, 0, 0);
        chk("raw cnt", int'(cnt1), 2);
        chk("raw head", int'({ext1, ch1}), 9'h0F0);
        tick(0, 0, 8'h00, 8'h00, 1, 0);
        chk("raw head2", int'({ext1, ch1}), 9'h01C);
        tick(0, 1, 8'h00, 8'h00, 0, 0);
        chk("raw err", int'(err1), 0);
        chk("dec err", int'(err0), 1);
        chk("raw cnt2", int'(cnt1), 2);
        tick(0, 1, 8'hE1, 8'h00, 0, 0);
        chk("raw cnt3", int'(cnt1), 3);

        // Reset in the middle of a Pause sequence
        tick(1, 0, 8'h00, 8'h00, 0, 0);
        tick(0, 1, 8'hE1, 8'h00, 0, 0);
        tick(0, 1, 8'h14, 8'h1D, 0, 0);
        tick(1, 0, 8'h00, 8'h00, 0, 0);
        tick(0, 1, 8'h1C, 8'h1E, 0, 0);
        chk("midrst hit", int'(hit0), 1);
        chk("midrst ch", int'(ch0), 8'h1E);
        chk("midrst ext", int'(ext0), 0);
        chk("midrst cnt", int'(cnt0), 1);

        // Random traffic against the model
        tick(1, 0, 8'h00, 8'h00, 0, 0);
        for (int n = 0; n < 3000; n++) begin
            r   = ($urandom_range(0, 199) == 0);
            v   = ($urandom_range(0, 9) < 6);
            p   = ($urandom_range(0, 3) == 0);
            c   = ($urandom_range(0, 19) == 0);
            sel = $urandom_range(0, 11);
            x   = 8'($urandom);
            case (sel)
                0:       a = 8'hF0;
                1:       a = 8'hE0;
                2:       a = 8'hE1;
                3:       a = 8'h00;
                4:       a = 8'hFF;
                default: a = 8'($urandom);
            endcase
            tick(r, v, a, x, p, c);
            cmp_model(0, n);
            cmp_model(1, n);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
